// File: rtl/decode_pkg.sv
// Decode-stage shared definitions: opcode map, control bundle layout and the
// opcode -> {mem, ex, wb} control decoder.
package decode_pkg;

   localparam int unsigned MemW = 4;
   localparam int unsigned ExW  = 6;
   localparam int unsigned WbW  = 3;

   // ex_mem bit positions
   localparam int unsigned MemRead  = 3;
   localparam int unsigned MemWrite = 2;
   localparam int unsigned MemAddr  = 1;
   localparam int unsigned MemData  = 0;

   // ex_ex bit positions: ALUop occupies [5:2]
   localparam int unsigned ExAluOpLsb = 2;
   localparam int unsigned ExAluEn    = 1;
   localparam int unsigned ExShamSel  = 0;

   localparam logic [1:0] WbSelAlu = 2'd0;
   localparam logic [1:0] WbSelMem = 2'd1;

   localparam logic [3:0] AluAdd = 4'd0;
   localparam logic [3:0] AluSub = 4'd1;
   localparam logic [3:0] AluAnd = 4'd2;
   localparam logic [3:0] AluOr  = 4'd3;
   localparam logic [3:0] AluShl = 4'd4;
   localparam logic [3:0] AluShr = 4'd5;

   // Opcodes are compared zero-extended to 32 bits so any OPW up to 32 works.
   localparam logic [31:0] OpNop   = 32'h00;
   localparam logic [31:0] OpAdd   = 32'h01;
   localparam logic [31:0] OpSub   = 32'h02;
   localparam logic [31:0] OpAnd   = 32'h03;
   localparam logic [31:0] OpOr    = 32'h04;
   localparam logic [31:0] OpShl   = 32'h05;
   localparam logic [31:0] OpShr   = 32'h06;
   localparam logic [31:0] OpLoad  = 32'h10;
   localparam logic [31:0] OpStore = 32'h11;

   typedef struct packed {
      logic [MemW-1:0] mem;
      logic [ExW-1:0]  ex;
      logic [WbW-1:0]  wb;
   } ctrl_t;

   function automatic ctrl_t alu_ctrl(input logic [3:0] alu_op, input logic sham);
      ctrl_t c;
      c = '0;
      c.ex[ExAluOpLsb +: 4] = alu_op;
      c.ex[ExAluEn]         = 1'b1;
      c.ex[ExShamSel]       = sham;
      c.wb                  = {1'b1, WbSelAlu};
      return c;
   endfunction

   // Unknown opcodes decode to all-zero control (NOP).
   function automatic ctrl_t decode_ctrl(input logic [31:0] opcode);
      ctrl_t c;
      c = '0;
      case (opcode)
         OpAdd:   c = alu_ctrl(AluAdd, 1'b0);
         OpSub:   c = alu_ctrl(AluSub, 1'b0);
         OpAnd:   c = alu_ctrl(AluAnd, 1'b0);
         OpOr:    c = alu_ctrl(AluOr,  1'b0);
         OpShl:   c = alu_ctrl(AluShl, 1'b1);
         OpShr:   c = alu_ctrl(AluShr, 1'b1);
         OpLoad: begin
            c                 = alu_ctrl(AluAdd, 1'b0);
            c.mem[MemRead]    = 1'b1;
            c.mem[MemAddr]    = 1'b1;
            c.wb              = {1'b1, WbSelMem};
         end
         OpStore: begin
            c                 = alu_ctrl(AluAdd, 1'b0);
            c.mem[MemWrite]   = 1'b1;
            c.mem[MemAddr]    = 1'b1;
            c.mem[MemData]    = 1'b1;
            c.wb              = '0;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/decode_regfile.sv
// Decode register file: 2**N x W, two combinational read ports, one write port.
// DECODE_BYPASS_EN: a same-cycle write to the addressed register is forwarded to the reads.
module decode_regfile
   import decode_pkg::*;
#(
   parameter int unsigned W       = 16,
   parameter int unsigned N       = 3,
   parameter int unsigned R0_ZERO = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we_i,
   input  logic [N-1:0] wa_i,
   input  logic [W-1:0] wd_i,
   input  logic [N-1:0] ra_a_i,
   input  logic [N-1:0] ra_b_i,
   output logic [W-1:0] rd_a_o,
   output logic [W-1:0] rd_b_o
);

   localparam int unsigned NRegs = 2 ** N;

   logic [W-1:0] regs_q [NRegs];
   logic         wr_en;

   // With R0_ZERO, r0 is never written, so it stays at its reset value of 0.
   assign wr_en = we_i && !((R0_ZERO != 0) && (wa_i == '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q <= '{default: '0};
      end else if (wr_en) begin
         regs_q[wa_i] <= wd_i;
      end
   end

   always_comb begin
      rd_a_o = regs_q[ra_a_i];
      rd_b_o = regs_q[ra_b_i];
`ifdef DECODE_BYPASS_EN
      if (wr_en && (wa_i == ra_a_i)) rd_a_o = wd_i;
      if (wr_en && (wa_i == ra_b_i)) rd_b_o = wd_i;
`endif
   end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: register file, opcode decode and the ID/EX pipeline register with
// load-use bubble, stall hold and flush. DECODE_BYPASS_EN enables regfile write-through.
module decode_stage_pipe
   import decode_pkg::*;
#(
   parameter int unsigned W       = 16,
   parameter int unsigned N       = 3,
   parameter int unsigned OPW     = 6,
   parameter int unsigned R0_ZERO = 0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           id_valid,
   input  logic [OPW-1:0] opcode,
   input  logic [N-1:0]   src,
   input  logic [N-1:0]   dst,
   input  logic           wb_we,
   input  logic [N-1:0]   wb_wa,
   input  logic [W-1:0]   wb_wd,
   input  logic           ex_stall,
   input  logic           flush,
   output logic           hazard_stall,
   output logic           ex_valid,
   output logic [W-1:0]   ex_rsrc,
   output logic [W-1:0]   ex_rdst,
   output logic [N-1:0]   ex_src_a,
   output logic [N-1:0]   ex_dst_a,
   output logic [MemW-1:0] ex_mem,
   output logic [ExW-1:0]  ex_ex,
   output logic [WbW-1:0]  ex_wb
);

   logic [W-1:0] rd_src, rd_dst;
   ctrl_t        ctrl;

   logic         ex_valid_q, ex_valid_d;
   logic [W-1:0] ex_rsrc_q, ex_rsrc_d;
   logic [W-1:0] ex_rdst_q, ex_rdst_d;
   logic [N-1:0] ex_src_a_q, ex_src_a_d;
   logic [N-1:0] ex_dst_a_q, ex_dst_a_d;
   ctrl_t        ex_ctrl_q, ex_ctrl_d;
   logic         bubble;

   decode_regfile #(
      .W       (W),
      .N       (N),
      .R0_ZERO (R0_ZERO)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .we_i   (wb_we),
      .wa_i   (wb_wa),
      .wd_i   (wb_wd),
      .ra_a_i (src),
      .ra_b_i (dst),
      .rd_a_o (rd_src),
      .rd_b_o (rd_dst)
   );

   assign ctrl = decode_ctrl(32'(opcode));

   assign hazard_stall = id_valid & ex_valid_q & ex_ctrl_q.mem[MemRead] &
                         ((ex_dst_a_q == src) | (ex_dst_a_q == dst)) & ~flush;

   // Flush beats stall; a load-use hazard only bubbles when EX is accepting.
   assign bubble = flush | (~ex_stall & hazard_stall);

   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_rsrc_d  = ex_rsrc_q;
      ex_rdst_d  = ex_rdst_q;
      ex_src_a_d = ex_src_a_q;
      ex_dst_a_d = ex_dst_a_q;
      ex_ctrl_d  = ex_ctrl_q;
      if (bubble) begin
         ex_valid_d = 1'b0;
         ex_rsrc_d  = '0;
         ex_rdst_d  = '0;
         ex_src_a_d = '0;
         ex_dst_a_d = '0;
         ex_ctrl_d  = '0;
      end else if (!ex_stall) begin
         ex_valid_d = id_valid;
         ex_rsrc_d  = rd_src;
         ex_rdst_d  = rd_dst;
         ex_src_a_d = src;
         ex_dst_a_d = dst;
         ex_ctrl_d  = id_valid ? ctrl : '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid_q <= 1'b0;
         ex_rsrc_q  <= '0;
         ex_rdst_q  <= '0;
         ex_src_a_q <= '0;
         ex_dst_a_q <= '0;
         ex_ctrl_q  <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_rsrc_q  <= ex_rsrc_d;
         ex_rdst_q  <= ex_rdst_d;
         ex_src_a_q <= ex_src_a_d;
         ex_dst_a_q <= ex_dst_a_d;
         ex_ctrl_q  <= ex_ctrl_d;
      end
   end

   assign ex_valid = ex_valid_q;
   assign ex_rsrc  = ex_rsrc_q;
   assign ex_rdst  = ex_rdst_q;
   assign ex_src_a = ex_src_a_q;
   assign ex_dst_a = ex_dst_a_q;
   assign ex_mem   = ex_ctrl_q.mem;
   assign ex_ex    = ex_ctrl_q.ex;
   assign ex_wb    = ex_ctrl_q.wb;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Scoreboard bench for decode_stage_pipe: default instance plus a W=32, N=4, R0_ZERO=1 one.
module tb_decode_stage_pipe;

`ifdef DECODE_BYPASS_EN
   localparam bit Byp = 1'b1;
`else
   localparam bit Byp = 1'b0;
`endif

   // Hand-coded control encodings
   localparam logic [5:0] OP_ADD = 6'h01, OP_SUB = 6'h02, OP_AND = 6'h03, OP_OR = 6'h04;
   localparam logic [5:0] OP_SHL = 6'h05, OP_SHR = 6'h06, OP_LD = 6'h10, OP_ST = 6'h11;
   localparam logic [5:0] OP_BAD = 6'h3F;
   localparam logic [5:0] EX_ADD = 6'b000010, EX_SUB = 6'b000110, EX_AND = 6'b001010;
   localparam logic [5:0] EX_OR = 6'b001110, EX_SHL = 6'b010011;
   localparam logic [3:0] M_LD = 4'b1010, M_ST = 4'b0111;
   localparam logic [2:0] WB_ALU = 3'b100, WB_LD = 3'b101;

   logic clk = 1'b0;
   logic rst;
   logic id_valid, wb_we, ex_stall, flush;
   logic [5:0] opcode;
   logic [2:0] src, dst, wb_wa;
   logic [15:0] wb_wd;
   logic hazard_stall, ex_valid;
   logic [15:0] ex_rsrc, ex_rdst;
   logic [2:0] ex_src_a, ex_dst_a;
   logic [3:0] ex_mem;
   logic [5:0] ex_ex;
   logic [2:0] ex_wb;

   logic d2_id_valid, d2_wb_we;
   logic [5:0] d2_opcode;
   logic [3:0] d2_src, d2_dst, d2_wb_wa;
   logic [31:0] d2_wb_wd;
   logic d2_hazard_stall, d2_ex_valid;
   logic [31:0] d2_ex_rsrc, d2_ex_rdst;
   logic [3:0] d2_ex_src_a, d2_ex_dst_a;
   logic [3:0] d2_ex_mem;
   logic [5:0] d2_ex_ex;
   logic [2:0] d2_ex_wb;

   always #5 clk = ~clk;

   decode_stage_pipe u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .opcode(opcode), .src(src), .dst(dst),
      .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .ex_stall(ex_stall), .flush(flush),
      .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_rsrc(ex_rsrc), .ex_rdst(ex_rdst),
      .ex_src_a(ex_src_a), .ex_dst_a(ex_dst_a), .ex_mem(ex_mem), .ex_ex(ex_ex), .ex_wb(ex_wb)
   );

   decode_stage_pipe #(.W(32), .N(4), .OPW(6), .R0_ZERO(1)) u_dut2 (
      .clk(clk), .rst(rst), .id_valid(d2_id_valid), .opcode(d2_opcode), .src(d2_src),
      .dst(d2_dst), .wb_we(d2_wb_we), .wb_wa(d2_wb_wa), .wb_wd(d2_wb_wd), .ex_stall(1'b0),
      .flush(1'b0), .hazard_stall(d2_hazard_stall), .ex_valid(d2_ex_valid),
      .ex_rsrc(d2_ex_rsrc), .ex_rdst(d2_ex_rdst), .ex_src_a(d2_ex_src_a),
      .ex_dst_a(d2_ex_dst_a), .ex_mem(d2_ex_mem), .ex_ex(d2_ex_ex), .ex_wb(d2_ex_wb)
   );

   typedef struct {
      logic [3:0]  mem;
      logic [5:0]  ex;
      logic [2:0]  wb;
      logic [15:0] rs;
      logic [15:0] rd;
      logic [2:0]  sa;
      logic [2:0]  da;
   } exp_t;

   exp_t exp_q[$];
   exp_t last_exp;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cmp(input string tag, input exp_t x);
      chk({tag, ".mem"},  32'(ex_mem),   32'(x.mem));
      chk({tag, ".ex"},   32'(ex_ex),    32'(x.ex));
      chk({tag, ".wb"},   32'(ex_wb),    32'(x.wb));
      chk({tag, ".rsrc"}, 32'(ex_rsrc),  32'(x.rs));
      chk({tag, ".rdst"}, 32'(ex_rdst),  32'(x.rd));
      chk({tag, ".srca"}, 32'(ex_src_a), 32'(x.sa));
      chk({tag, ".dsta"}, 32'(ex_dst_a), 32'(x.da));
   endtask

   // Monitor: a fresh ID/EX value pops the queue; a held one is checked against the last pop.
   initial begin
      logic stall_prev;
      exp_t e;
      forever begin
         @(posedge clk);
         stall_prev = ex_stall;
         @(negedge clk);
         if (ex_valid === 1'b1) begin
            if (stall_prev) begin
               cmp("hold", last_exp);
            end else if (exp_q.size() == 0) begin
               chk("unexpected_valid", 32'(ex_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               last_exp = e;
               cmp("issue", e);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [5:0] op, input logic [2:0] s, input logic [2:0] d);
      id_valid = 1'b1;
      opcode   = op;
      src      = s;
      dst      = d;
   endtask

   task automatic issue(input logic [5:0] op, input logic [2:0] s, input logic [2:0] d,
                        input logic [3:0] m, input logic [5:0] e, input logic [2:0] w,
                        input logic [15:0] rs, input logic [15:0] rd);
      exp_t x;
      present(op, s, d);
      x.mem = m; x.ex = e; x.wb = w; x.rs = rs; x.rd = rd; x.sa = s; x.da = d;
      exp_q.push_back(x);
   endtask

   task automatic idle();
      id_valid = 1'b0;
      opcode   = '0;
      src      = '0;
      dst      = '0;
   endtask

   task automatic wb_write(input logic [2:0] a, input logic [15:0] d);
      wb_we = 1'b1; wb_wa = a; wb_wd = d;
      tick();
      wb_we = 1'b0;
   endtask

   task automatic check_bubble(input string tag);
      chk({tag, ".valid"}, 32'(ex_valid), 32'd0);
      chk({tag, ".mem"},   32'(ex_mem),   32'd0);
      chk({tag, ".ex"},    32'(ex_ex),    32'd0);
      chk({tag, ".wb"},    32'(ex_wb),    32'd0);
   endtask

   initial begin
      rst = 1'b1; wb_we = 1'b0; wb_wa = '0; wb_wd = '0; ex_stall = 1'b0; flush = 1'b0;
      idle();
      d2_id_valid = 1'b0; d2_opcode = '0; d2_src = '0; d2_dst = '0;
      d2_wb_we = 1'b0; d2_wb_wa = '0; d2_wb_wd = '0;
      tick(); tick();
      rst = 1'b0;
      #1;
      check_bubble("reset");
      chk("reset.rsrc", 32'(ex_rsrc), 32'd0);
      chk("reset.hazard", 32'(hazard_stall), 32'd0);

      wb_write(3'd1, 16'h0011);
      wb_write(3'd2, 16'h0022);
      wb_write(3'd3, 16'h1234);
      wb_write(3'd5, 16'h0055);
      wb_write(3'd6, 16'h0066);

      // Basic decode patterns
      issue(OP_ADD, 3'd1, 3'd2, 4'b0, EX_ADD, WB_ALU, 16'h0011, 16'h0022); tick();
      issue(OP_SHL, 3'd3, 3'd6, 4'b0, EX_SHL, WB_ALU, 16'h1234, 16'h0066); tick();
      issue(OP_BAD, 3'd5, 3'd1, 4'b0, 6'b0,   3'b0,   16'h0055, 16'h0011); tick();
      issue(OP_ST,  3'd2, 3'd3, M_ST, EX_ADD, 3'b0,   16'h0022, 16'h1234); tick();
      idle(); tick();

      // Load-use on src
      issue(OP_LD, 3'd1, 3'd2, M_LD, EX_ADD, WB_LD, 16'h0011, 16'h0022); tick();
      present(OP_ADD, 3'd2, 3'd5);
      #1 chk("loaduse.hazard", 32'(hazard_stall), 32'd1);
      tick();
      check_bubble("loaduse.bubble");
      chk("loaduse.hazard_after", 32'(hazard_stall), 32'd0);
      issue(OP_ADD, 3'd2, 3'd5, 4'b0, EX_ADD, WB_ALU, 16'h0022, 16'h0055); tick();
      idle(); tick();

      // Load-use on dst, then flush with stall: flush wins
      issue(OP_LD, 3'd0, 3'd6, M_LD, EX_ADD, WB_LD, 16'h0000, 16'h0066); tick();
      present(OP_ADD, 3'd1, 3'd6);
      #1 chk("dsthaz.hazard", 32'(hazard_stall), 32'd1);
      flush = 1'b1; ex_stall = 1'b1;
      #1 chk("flush.hazard", 32'(hazard_stall), 32'd0);
      tick();
      check_bubble("flush.bubble");
      chk("flush.dsta", 32'(ex_dst_a), 32'd0);
      flush = 1'b0; ex_stall = 1'b0; idle(); tick();

      // Execute stall hold for 3 cycles, then release
      issue(OP_OR, 3'd5, 3'd6, 4'b0, EX_OR, WB_ALU, 16'h0055, 16'h0066); tick();
      ex_stall = 1'b1;
      present(OP_AND, 3'd1, 3'd2);
      tick(); tick(); tick();
      ex_stall = 1'b0;
      issue(OP_AND, 3'd1, 3'd2, 4'b0, EX_AND, WB_ALU, 16'h0011, 16'h0022); tick();
      idle(); tick();

      // WB/decode collision
      wb_we = 1'b1; wb_wa = 3'd5; wb_wd = 16'hBEEF;
      issue(OP_SUB, 3'd5, 3'd1, 4'b0, EX_SUB, WB_ALU, Byp ? 16'hBEEF : 16'h0055, 16'h0011);
      tick();
      wb_wa = 3'd1; wb_wd = 16'h0101;
      issue(OP_ADD, 3'd5, 3'd1, 4'b0, EX_ADD, WB_ALU, 16'hBEEF, Byp ? 16'h0101 : 16'h0011);
      tick();
      wb_we = 1'b0;
      issue(OP_ADD, 3'd1, 3'd5, 4'b0, EX_ADD, WB_ALU, 16'h0101, 16'hBEEF); tick();
      idle(); tick();

      // Mid-operation reset drops the in-flight instruction and clears the file
      issue(OP_ADD, 3'd3, 3'd3, 4'b0, EX_ADD, WB_ALU, 16'h1234, 16'h1234); tick();
      present(OP_SHR, 3'd3, 3'd3);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_bubble("midrst");
      chk("midrst.rsrc", 32'(ex_rsrc), 32'd0);
      tick(); tick();
      rst = 1'b0; idle(); tick();
      issue(OP_ADD, 3'd3, 3'd1, 4'b0, EX_ADD, WB_ALU, 16'h0000, 16'h0000); tick();
      idle(); tick();

      // R0_ZERO instance
      d2_wb_we = 1'b1; d2_wb_wa = 4'd0; d2_wb_wd = 32'hFFFF_FFFF; tick();
      d2_wb_wa = 4'd15; d2_wb_wd = 32'hCAFE_F00D; tick();
      d2_wb_wa = 4'd0; d2_wb_wd = 32'hFFFF_FFFF;
      d2_id_valid = 1'b1; d2_opcode = OP_ADD; d2_src = 4'd0; d2_dst = 4'd15;
      tick();
      d2_wb_we = 1'b0;
      chk("r0z.valid", 32'(d2_ex_valid), 32'd1);
      chk("r0z.r0",    d2_ex_rsrc,       32'h0);
      chk("r0z.r15",   d2_ex_rdst,       32'hCAFE_F00D);
      chk("r0z.dsta",  32'(d2_ex_dst_a), 32'd15);
      chk("r0z.ex",    32'(d2_ex_ex),    32'(EX_ADD));
      d2_src = 4'd15; d2_dst = 4'd0;
      tick();
      chk("r0z.swap_src", d2_ex_rsrc, 32'hCAFE_F00D);
      chk("r0z.swap_dst", d2_ex_rdst, 32'h0);
      d2_id_valid = 1'b0;
      tick(); tick();

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
